irq_controller: RTL and testbench
=================================

# irq_controller

Memory-mapped interrupt controller that sits directly downstream of `system_timer` and the other peripheral interrupt sources. It latches level- or edge-triggered source requests into a pending register, masks them with an enable register, and drives one interrupt line to the core. The core claims the highest-priority request and later completes it over the same `sel`/`addr`/`wen` register bus the timer uses. `system_timer.irq` connects to `src_irq[0]`.

## Interface
- `NUM_SRC`, 8, number of sources, 1..32; index 0 has the highest priority.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sel`  in  1  block select from the bus decoder.
- `addr`  in  3  register index.
- `wdata`  in  32  write data.
- `wen`  in  1  write strobe; writes commit on the rising edge when `sel & wen`.
- `rdata`  out  32  read data, combinational from `addr` when `sel=1`; 0 when `sel=0`.
- `src_irq`  in  NUM_SRC  source requests, synchronous to `clk`.
- `ext_irq`  out  1  registered interrupt request to the core.
- `ext_irq_id`  out  5  registered ID of the request currently signalled.

## Operation
Registers; bits at or above NUM_SRC read 0 and ignore writes:
- 0 PENDING: read-only; writing 1 clears the bit for edge-mode sources only.
- 1 ENABLE: read/write.
- 2 TRIGGER: read/write; 1 = rising-edge mode, 0 = level mode.
- 3 CLAIM: a read returns `{valid[31], 26'b0, id[4:0]}`. Writing `wdata[4:0]` performs a complete.
- 4 STATUS: read-only; bit0 = busy, bits[12:8] = in-service ID.
- 5–7: read 0; writes ignored.

Pending behaviour:
- `src_q` holds the previous sample of `src_irq`.
- Edge source: pending sets on the edge where `src_irq & ~src_q`. It clears on claim of that ID or on a PENDING W1C.
- Level source: pending bit = `src_q`.
- Candidate = lowest index with `pending & enable`.

State machine (`busy` reflects the state):
- IDLE → SERVING on a claim read that returns valid=1. Latch the in-service ID; clear pending if that source is edge mode. With no candidate, the read returns 0 and the state is unchanged.
- A claim read fires once per access: on the first cycle of `sel & ~wen & addr==3`, detected against the previous cycle. Holding the address for more cycles causes no further claims.
- SERVING → IDLE on a complete write whose ID equals the in-service ID. A mismatched ID is ignored.
- A complete write in IDLE is ignored.

Outputs:
- `ext_irq` = registered (state==IDLE & candidate exists).
- `ext_irq_id` = registered candidate ID; 0 when there is no candidate.

Boundary and simultaneous events:
- New edge and clear (claim or W1C) on the same source in the same cycle: set wins; pending stays 1.
- An edge arriving during SERVING is latched and signalled after complete.
- Clearing ENABLE while `ext_irq=1` drops `ext_irq` on the next edge; pending is kept.
- Changing TRIGGER from level to edge does not clear pending; the bit is then cleared only by W1C or claim.
- Reset mid-operation: all registers cleared and state returns to IDLE.

## Timing
- Reset values: PENDING, ENABLE and TRIGGER = 0; `src_q` = 0; state IDLE; `ext_irq` = 0; `ext_irq_id` = 0; `rdata` = 0 while `sel=0`.
- Source to `ext_irq` latency: a source rising before edge E1 sets pending at E1, and `ext_irq` rises at E2.
- Claim read at edge Ec: `rdata` is valid combinationally in that cycle before Ec. State becomes SERVING at Ec, and `ext_irq` falls at Ec+1.
- Complete write at edge Ed: state is IDLE at Ed. If a candidate remains, `ext_irq` reasserts at Ed+1.
- Register writes take effect at the commit edge; readback is visible in the next cycle.

## Test plan
- Reset defaults: all registers read 0, `ext_irq=0`, `ext_irq_id=0`.
- Level source: ENABLE=0x1, TRIGGER=0, `src_irq[0]=1` → `ext_irq=1` two edges later with ID 0. CLAIM reads 0x8000_0000; STATUS reads 0x0000_0001; `ext_irq=0`. Complete with 0 while the source is still high → `ext_irq` reasserts. Drop the source → `ext_irq=0`.
- Edge plus priority: TRIGGER=0xFF, ENABLE=0x84, one-cycle pulses on sources 2 and 7 together. CLAIM returns 0x8000_0002 and PENDING reads 0x80. Complete with 5 is ignored and STATUS stays 0x0201. Complete with 2, then CLAIM returns 0x8000_0007.
- Set-versus-clear collision: pulse edge source 3 in the same cycle as a W1C of PENDING bit 3 → PENDING bit 3 reads 1.
- Mask and unmapped addresses: ENABLE=0 with PENDING=0x10 → `ext_irq=0`, and CLAIM reads 0 with no state change. Reads of addresses 5–7 return 0.
- Timer integration: `system_timer` with LOAD=0x2 and CTRL=0x3 on `src_irq[0]` → `ext_irq` asserts with ID 0. Claim/complete cycles repeat on every timer reload.

Source files
------------

// File: rtl/irq_controller.sv
// Interrupt controller: latches level/edge source requests,
// masks with ENABLE, signals the lowest-index request, claim/complete.
module irq_controller #(
  parameter int NUM_SRC = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sel,
  input  logic [2:0]         i_addr,
  input  logic [31:0]        i_wdata,
  input  logic               i_wen,
  output logic [31:0]        o_rdata,
  input  logic [NUM_SRC-1:0] i_src_irq,
  output logic               o_ext_irq,
  output logic [4:0]         o_ext_irq_id
);

  typedef enum logic {
    S_IDLE,
    S_SERVING
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_en;
  logic [NUM_SRC-1:0] r_trig;
  logic [NUM_SRC-1:0] r_src_q;
  logic [4:0]         r_isr_id;
  logic               r_claim_q;

  logic [NUM_SRC-1:0] w_act;
  logic [NUM_SRC-1:0] w_w1c;
  logic [NUM_SRC-1:0] w_claim_clr;
  logic [NUM_SRC-1:0] w_pend_nxt;
  logic               w_cand_vld;
  logic [4:0]         w_cand_id;
  logic               w_wr;
  logic               w_rd_claim;
  logic               w_claim;
  logic               w_complete;
  logic               w_idle;

  assign w_idle     = (r_state == S_IDLE);
  assign w_wr       = i_sel & i_wen;
  assign w_rd_claim = i_sel & ~i_wen & (i_addr == 3'd3);
  assign w_claim    = w_rd_claim & ~r_claim_q & w_idle & w_cand_vld;
  assign w_complete = w_wr & (i_addr == 3'd3) & ~w_idle
                    & (i_wdata[4:0] == r_isr_id);
  assign w_act      = r_pend & r_en;
  assign w_w1c      = (w_wr && i_addr == 3'd0) ?
                      i_wdata[NUM_SRC-1:0] : '0;

  // Lowest active index wins; also builds the claim clear mask
  always_comb begin
    w_cand_vld  = 1'b0;
    w_cand_id   = '0;
    w_claim_clr = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_cand_vld = 1'b1;
        w_cand_id  = 5'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      w_claim_clr[i] = w_claim && (w_cand_id == 5'(i));
    end
  end

  // Edge bits: a new edge beats any clear; level bits follow src_q
  always_comb begin
    w_pend_nxt = (r_trig & ((i_src_irq & ~r_src_q)
               | (r_pend & ~(w_w1c | w_claim_clr))))
               | (~r_trig & i_src_irq);
  end

  // Next state: claim enters service, matching complete leaves it
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_claim)    w_state_nxt = S_SERVING;
      S_SERVING: if (w_complete) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register and in-service ID
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_isr_id  <= '0;
      r_claim_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_claim_q <= w_rd_claim;
      if (w_claim)         r_isr_id <= w_cand_id;
      else if (w_complete) r_isr_id <= '0;
    end
  end

  // Source sampling, pending and config registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend  <= '0;
      r_en    <= '0;
      r_trig  <= '0;
      r_src_q <= '0;
    end else begin
      r_src_q <= i_src_irq;
      r_pend  <= w_pend_nxt;
      if (w_wr && i_addr == 3'd1) r_en   <= i_wdata[NUM_SRC-1:0];
      if (w_wr && i_addr == 3'd2) r_trig <= i_wdata[NUM_SRC-1:0];
    end
  end

  // Registered request line to the core
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ext_irq    <= 1'b0;
      o_ext_irq_id <= '0;
    end else begin
      o_ext_irq    <= w_idle & w_cand_vld;
      o_ext_irq_id <= w_cand_id;
    end
  end

  // Combinational register readback
  always_comb begin
    o_rdata = '0;
    if (i_sel) begin
      unique case (i_addr)
        3'd0:    o_rdata = 32'(r_pend);
        3'd1:    o_rdata = 32'(r_en);
        3'd2:    o_rdata = 32'(r_trig);
        3'd3:    o_rdata = {w_idle & w_cand_vld, 26'b0, w_cand_id};
        3'd4:    o_rdata = {19'b0, r_isr_id, 7'b0, ~w_idle};
        default: o_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: reset, level, edge/priority,
// collision, masking, periodic timer pulses, reset mid-service.
module tb_irq_controller;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        wen;
  logic [31:0] rdata;
  logic [7:0]  src;
  logic        ext_irq;
  logic [4:0]  ext_id;

  int n_cmp;
  int n_bad;

  irq_controller #(.NUM_SRC(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sel       (sel),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_wen       (wen),
    .o_rdata     (rdata),
    .i_src_irq   (src),
    .o_ext_irq   (ext_irq),
    .o_ext_irq_id(ext_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; wen = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; wen = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    sel = 1'b1; wen = 1'b0; addr = a;
    #1 d = rdata;
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    src = m;
    @(negedge clk);
    src = '0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), v);
      n_cmp++;
      if (v !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_reg%0d: got %h want %h", a, v, 32'h0);
      end
    end
    n_cmp++;
    if (ext_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_irq: got %b want 0", ext_irq);
    end
    n_cmp++;
    if (ext_id !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_id: got %0d want 0", ext_id);
    end
  endtask

  task automatic test_level;
    logic [31:0] v;
    wr(3'd1, 32'h1);
    src = 8'h01;
    @(negedge clk);
    n_cmp++;
    if (ext_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL lvl_early: got %b want 0", ext_irq);
    end
    @(negedge clk);
    n_cmp++;
    if (ext_irq !== 1'b1 || ext_id !== 5'd0) begin
      n_bad++;
      $display("FAIL lvl_irq: got %b/%0d want 1/0", ext_irq, ext_id);
    end
    rd(3'd3, v);
    n_cmp++;
    if (v !== 32'h8000_0000) begin
      n_bad++;
      $display("FAIL lvl_claim: got %h want 80000000", v);
    end
    rd(3'd4, v);
    n_cmp++;
    if (v !== 32'h0000_0001) begin
      n_bad++;
      $display("FAIL lvl_status: got %h want 00000001", v);
    end
    n_cmp++;
    if (ext_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL lvl_irq_fall: got %b want 0", ext_irq);
    end
    wr(3'd3, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (ext_irq !== 1'b1) begin
      n_bad++;
      $display("FAIL lvl_reassert: got %b want 1", ext_irq);
    end
    src = 8'h00;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (ext_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL lvl_drop: got %b want 0", ext_irq);
    end
    wr(3'd1, 32'h0);
  endtask

  task automatic test_edge_priority;
    logic [31:0] v;
    wr(3'd2, 32'hFF);
    wr(3'd1, 32'h84);
    pulse(8'h84);
    @(negedge clk);
    rd(3'd3, v);
    n_cmp++;
    if (v !== 32'h8000_0002) begin
      n_bad++;
      $display("FAIL edge_claim2: got %h want 80000002", v);
    end
    rd(3'd0, v);
    n_cmp++;
    if (v !== 32'h80) begin
      n_bad++;
      $display("FAIL edge_pend: got %h want 00000080", v);
    end
    wr(3'd3, 32'h5);
    rd(3'd4, v);
    n_cmp++;
    if (v !== 32'h0000_0201) begin
      n_bad++;
      $display("FAIL edge_badcomp: got %h want 00000201", v);
    end
    wr(3'd3, 32'h2);
    @(negedge clk);
    n_cmp++;
    if (ext_irq !== 1'b1 || ext_id !== 5'd7) begin
      n_bad++;
      $display("FAIL edge_next: got %b/%0d want 1/7", ext_irq, ext_id);
    end
    rd(3'd3, v);
    n_cmp++;
    if (v !== 32'h8000_0007) begin
      n_bad++;
      $display("FAIL edge_claim7: got %h want 80000007", v);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    pulse(8'h04);
    @(negedge clk);
    rd(3'd0, v);
    n_cmp++;
    if (v !== 32'h04) begin
      n_bad++;
      $display("FAIL b2b_pend: got %h want 00000004", v);
    end
    n_cmp++;
    if (ext_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_busy_irq: got %b want 0", ext_irq);
    end
    wr(3'd3, 32'h7);
    @(negedge clk);
    n_cmp++;
    if (ext_irq !== 1'b1 || ext_id !== 5'd2) begin
      n_bad++;
      $display("FAIL b2b_irq: got %b/%0d want 1/2", ext_irq, ext_id);
    end
    rd(3'd3, v);
    n_cmp++;
    if (v !== 32'h8000_0002) begin
      n_bad++;
      $display("FAIL b2b_claim: got %h want 80000002", v);
    end
    wr(3'd3, 32'h2);
    wr(3'd1, 32'h0);
  endtask

  task automatic test_collision;
    logic [31:0] v;
    src = 8'h08;
    wr(3'd0, 32'h08);
    src = 8'h00;
    rd(3'd0, v);
    n_cmp++;
    if (v !== 32'h08) begin
      n_bad++;
      $display("FAIL collide_set: got %h want 00000008", v);
    end
    wr(3'd0, 32'h08);
    rd(3'd0, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_bad++;
      $display("FAIL collide_w1c: got %h want 00000000", v);
    end
  endtask

  task automatic test_mask;
    logic [31:0] v;
    pulse(8'h10);
    @(negedge clk);
    rd(3'd0, v);
    n_cmp++;
    if (v !== 32'h10) begin
      n_bad++;
      $display("FAIL mask_pend: got %h want 00000010", v);
    end
    n_cmp++;
    if (ext_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL mask_irq: got %b want 0", ext_irq);
    end
    rd(3'd3, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_bad++;
      $display("FAIL mask_claim: got %h want 00000000", v);
    end
    rd(3'd4, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_bad++;
      $display("FAIL mask_status: got %h want 00000000", v);
    end
    for (int a = 5; a < 8; a++) begin
      wr(3'(a), 32'hFFFF_FFFF);
      rd(3'(a), v);
      n_cmp++;
      if (v !== 32'h0) begin
        n_bad++;
        $display("FAIL unmapped%0d: got %h want 00000000", a, v);
      end
    end
    wr(3'd1, 32'hFFFF_FF10);
    addr = 3'd1;
    #1;
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL nosel_rdata: got %h want 00000000", rdata);
    end
    rd(3'd1, v);
    n_cmp++;
    if (v !== 32'h10) begin
      n_bad++;
      $display("FAIL en_width: got %h want 00000010", v);
    end
    n_cmp++;
    if (ext_irq !== 1'b1 || ext_id !== 5'd4) begin
      n_bad++;
      $display("FAIL unmask_irq: got %b/%0d want 1/4", ext_irq, ext_id);
    end
    wr(3'd1, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (ext_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL remask_irq: got %b want 0", ext_irq);
    end
    rd(3'd0, v);
    n_cmp++;
    if (v !== 32'h10) begin
      n_bad++;
      $display("FAIL remask_pend: got %h want 00000010", v);
    end
    wr(3'd0, 32'h10);
  endtask

  task automatic test_timer;
    logic [31:0] v;
    wr(3'd1, 32'h1);
    for (int k = 0; k < 3; k++) begin
      pulse(8'h01);
      @(negedge clk);
      n_cmp++;
      if (ext_irq !== 1'b1 || ext_id !== 5'd0) begin
        n_bad++;
        $display("FAIL tmr%0d_irq: got %b/%0d want 1/0",
                 k, ext_irq, ext_id);
      end
      rd(3'd3, v);
      n_cmp++;
      if (v !== 32'h8000_0000) begin
        n_bad++;
        $display("FAIL tmr%0d_claim: got %h want 80000000", k, v);
      end
      wr(3'd3, 32'h0);
      rd(3'd4, v);
      n_cmp++;
      if (v !== 32'h0) begin
        n_bad++;
        $display("FAIL tmr%0d_status: got %h want 00000000", k, v);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    pulse(8'h01);
    @(negedge clk);
    rd(3'd3, v);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ext_irq !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_irq: got %b want 0", ext_irq);
    end
    @(negedge clk);
    rd(3'd4, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_bad++;
      $display("FAIL rstmid_status: got %h want 00000000", v);
    end
    rd(3'd2, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_bad++;
      $display("FAIL rstmid_trig: got %h want 00000000", v);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    sel   = 1'b0;
    wen   = 1'b0;
    addr  = '0;
    wdata = '0;
    src   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_level;
    test_edge_priority;
    test_back_to_back;
    test_collision;
    test_mask;
    test_timer;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
